// File: rtl/bram_rd_pkg.sv
// bram_rd_pkg: shared state type, default widths and length helper for the BRAM stream reader
package bram_rd_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic int unsigned eff_len(int unsigned len, int unsigned aw);
    return len == 0 ? 32'd1 << aw : len;
  endfunction
endpackage

// File: rtl/bram_rd_fifo.sv
// bram_rd_fifo: first-word-fall-through FIFO with occupancy count
module bram_rd_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rstn,
  input  logic wr_en,
  input  logic [W-1:0] wr_data,
  input  logic rd_en,
  output logic [W-1:0] rd_data,
  output logic empty,
  output logic [CW-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty = count == '0;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) wr_ptr <= nxt(wr_ptr);
      if (rd_en) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(wr_en && count == CW'(DEPTH)));
  no_underflow: assert property (@(posedge clk) disable iff (!rstn) !(rd_en && empty));
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams a wrapping BRAM port-B address range out as AXI4-Stream
module bram_stream_reader
  import bram_rd_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH = READ_LATENCY + 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  output logic busy,
  output logic done,
  output logic bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic m_axis_tvalid,
  input  logic m_axis_tready,
  output logic m_axis_tlast
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_t state;
  logic [ADDR_W:0] remaining;
  logic [READ_LATENCY-1:0] pipe_v, pipe_l;
  logic [CW-1:0] fifo_count;
  logic [DATA_W:0] head;
  logic empty, hs, last_issue;
  // reads cannot stall, so every in-flight read must already own a FIFO slot
  assign bram_en = state == RUN && remaining != '0 &&
                   ($countones(pipe_v) + int'(fifo_count)) < FIFO_DEPTH;
  assign last_issue = bram_en && remaining == (ADDR_W + 1)'(1);
  assign busy = state != IDLE;
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata = empty ? '0 : head[DATA_W-1:0];
  assign m_axis_tlast = !empty && head[DATA_W];
  assign hs = m_axis_tvalid && m_axis_tready;
  bram_rd_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .wr_en(pipe_v[READ_LATENCY-1]),
    .wr_data({pipe_l[READ_LATENCY-1], bram_dout}),
    .rd_en(hs),
    .rd_data(head),
    .empty(empty),
    .count(fifo_count)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      remaining <= '0;
      bram_addr <= '0;
      pipe_v <= '0;
      pipe_l <= '0;
      done <= 1'b0;
    end else begin
      pipe_v <= (pipe_v << 1) | READ_LATENCY'(bram_en);
      pipe_l <= (pipe_l << 1) | READ_LATENCY'(last_issue);
      done <= hs && m_axis_tlast;
      if (state == IDLE && start && !done) begin
        state <= RUN;
        bram_addr <= start_addr;
        remaining <= (ADDR_W + 1)'(eff_len(32'(length), ADDR_W));
      end
      if (bram_en) begin
        bram_addr <= bram_addr + 1'b1;
        remaining <= remaining - 1'b1;
        if (last_issue) state <= DRAIN;
      end
      if (state == DRAIN && hs && m_axis_tlast) state <= IDLE;
    end
endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Reader-side master for the dual-port width-converting BRAM (port B: 1024 x 32).
- On a start command, reads a contiguous, wrapping address range from BRAM port B and emits it as an AXI4-Stream with full backpressure support.
- Sits between the capture buffer (filled through the 64-bit port A) and downstream DMA/stream logic.
- BRAM reads cannot stall, so a credit-limited output FIFO absorbs in-flight data.

Parameters:
ADDR_W, 10, port-B address width; buffer depth is 2**ADDR_W words
DATA_W, 32, port-B data width and stream width
READ_LATENCY, 2, cycles from bram_en/bram_addr to valid bram_dout (1..4)
FIFO_DEPTH, READ_LATENCY+2, output FIFO entries; must be >= READ_LATENCY+1

Ports:
clk  in  1  single clock, rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle command; sampled only in IDLE
start_addr  in  ADDR_W  first port-B address
length  in  ADDR_W  word count; 0 means 2**ADDR_W
busy  out  1  high from the cycle after start until the final handshake
done  out  1  one-cycle pulse after the final handshake
bram_en  out  1  port-B read enable
bram_addr  out  ADDR_W  port-B address
bram_dout  in  DATA_W  port-B read data
m_axis_tdata  out  DATA_W  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  marks the final word of the command

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; FIFO, counters and the latency pipe are cleared.
- States:
  - IDLE -> RUN on start (latch start_addr, length).
  - RUN -> DRAIN when the last read is issued.
  - DRAIN -> IDLE on the handshake of the tlast beat.
- Issue rule: bram_en=1 in RUN when remaining>0 and inflight+fifo_count < FIFO_DEPTH. Each issue increments bram_addr modulo 2**ADDR_W (wraps 1023->0) and decrements remaining.
- Latency pipe: a shift register of READ_LATENCY valid bits, plus a last-flag, tracks in-flight reads. bram_dout is written into the FIFO in the cycle its valid bit exits the pipe.
- Stream output is the FIFO head (first-word-fall-through):
  - tvalid = !empty.
  - tdata/tlast stay stable while tvalid && !tready.
  - Handshake = tvalid && tready.
- Timing (start sampled at edge 0, tready=1):
  - bram_en first high in cycle 1.
  - First tvalid in cycle 2+READ_LATENCY (cycle 4 at default).
  - Sustained throughput 1 word/cycle.
- tlast is asserted only on the word from the final issued address.
- On the cycle after the tlast handshake: done=1, busy=0.
- Simultaneous FIFO write and read in the same cycle: occupancy unchanged, no loss.
- start while busy: ignored. start in the same cycle as done: ignored; start is accepted one cycle later.
- rstn low mid-transfer: immediate abort, all in-flight data discarded, no done pulse.
- FIFO overflow and underflow are impossible by construction. An assertion checks this.

Decomposition:
- Package bram_rd_pkg: state enum (IDLE, RUN, DRAIN), default ADDR_W/DATA_W constants, and a function computing the effective length (0 -> 2**ADDR_W, carried in ADDR_W+1 bits).
- Sub-module bram_rd_fifo: synchronous FWFT FIFO, DATA_W+1 bits wide (data + last), parameterised depth, with count output.

Test Plan:
(BRAM model preloaded as in the existing capture flow: port-B address k holds value k.)
- start_addr=0, length=0, tready=1 -> 1024 beats of tdata 0..1023 with no gaps; first tvalid 4 cycles after start; tlast only on 1023; done one cycle after.
- start_addr=1020, length=8 -> tdata 1020,1021,1022,1023,0,1,2,3; tlast on 3; bram_addr wraps to 0.
- length=1, start_addr=5 -> exactly one beat, tdata=5 with tlast=1; busy high for 4 cycles (cycles 1..4); done pulse in cycle 5.
- tready held low for 20 cycles from beat 10 of a 64-word transfer -> at most FIFO_DEPTH=4 bram_en issued beyond the consumed words; tdata=10 stable throughout; resume yields 11.. with no loss or duplication.
- Random 50% tready over 512 words from addr 300 -> exact sequence 300..811 mod 1024; FIFO assertion never fires; start pulses issued while busy cause no effect.
- rstn pulsed low at beat 100 -> all outputs 0 within the reset cycle; no done; a following start (addr 0, length 4) yields 0..3 correctly.
